// File: rtl/cla_pkg.sv
// Shared constants for the sequential carry-lookahead adder.
package cla_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla4_slice.sv
// Purpose: 4-bit carry-lookahead adder slice.
// Latency: purely combinational.
// Backpressure: none; no state.
module cla4_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        s    = p ^ c[3:0];
        cout = c[4];
    end

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Purpose: WIDTH-bit add/subtract by iterating one 4-bit CLA slice, LSB slice first.
// Latency: out_valid rises WIDTH/4+1 cycles after the accept cycle; issue interval WIDTH/4+2.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module cla_seq_adder_ctrl
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             busy
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

    generate
        if ((WIDTH < SLICE_W) || ((WIDTH % SLICE_W) != 0)) begin : g_bad_width
            $error("cla_seq_adder_ctrl: WIDTH must be a positive multiple of 4");
        end
    endgenerate

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             carry_r;
    logic [IDX_W-1:0] idx;

    logic [SLICE_W-1:0] sl_a;
    logic [SLICE_W-1:0] sl_b;
    logic [SLICE_W-1:0] sl_s;
    logic               sl_cout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid)       state_nxt = S_RUN;
            S_RUN:   if (idx == IDX_LAST) state_nxt = S_DONE;
            S_DONE:  if (out_ready)      state_nxt = S_IDLE;
            default:                     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        busy      = (state == S_RUN);
        out_valid = (state == S_DONE);
    end

    assign sl_a = a_r[SLICE_W*idx +: SLICE_W];
    assign sl_b = b_r[SLICE_W*idx +: SLICE_W];

    cla4_slice u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_r),
        .s    (sl_s),
        .cout (sl_cout)
    );

    // Subtraction is folded into the operand latch: A + ~B + 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            sum_r   <= '0;
            carry_r <= 1'b0;
            idx     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_r     <= a;
                        b_r     <= op_sub ? ~b : b;
                        carry_r <= op_sub ? 1'b1 : c_in;
                        sum_r   <= '0;
                        idx     <= '0;
                    end
                end
                S_RUN: begin
                    sum_r[SLICE_W*idx +: SLICE_W] <= sl_s;
                    carry_r                       <= sl_cout;
                    idx                           <= idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Flags are qualified by DONE so they read zero straight out of reset.
    assign sum   = sum_r;
    assign c_out = carry_r;
    assign ovf   = out_valid && (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sum_r[WIDTH-1] != a_r[WIDTH-1]);
    assign zero  = out_valid && (sum_r == '0);

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Bench for cla_seq_adder_ctrl: directed 16-bit vectors, backpressure and reset
// sequences, then randomized traffic on 16, 4 and 32-bit builds.
module tb_cla_seq_adder_ctrl;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sub;
        logic [15:0] s;
        logic        c;
        logic        o;
        logic        z;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic        c_in = 1'b0;
    logic        op_sub = 1'b0;
    logic [2:0]  iv = '0;
    logic [2:0]  ordy = '0;
    logic [2:0]  irdy, ovld, cout, ovf, zero, busy;
    logic [15:0] s16;
    logic [3:0]  s4;
    logic [31:0] s32;
    logic [31:0] sum_k [3];

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    always_comb begin
        sum_k[0] = {16'h0, s16};
        sum_k[1] = {28'h0, s4};
        sum_k[2] = s32;
    end

    cla_seq_adder_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
        .a(opa[15:0]), .b(opb[15:0]), .c_in(c_in), .op_sub(op_sub),
        .out_valid(ovld[0]), .out_ready(ordy[0]), .sum(s16),
        .c_out(cout[0]), .ovf(ovf[0]), .zero(zero[0]), .busy(busy[0])
    );

    cla_seq_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
        .a(opa[3:0]), .b(opb[3:0]), .c_in(c_in), .op_sub(op_sub),
        .out_valid(ovld[1]), .out_ready(ordy[1]), .sum(s4),
        .c_out(cout[1]), .ovf(ovf[1]), .zero(zero[1]), .busy(busy[1])
    );

    cla_seq_adder_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
        .a(opa), .b(opb), .c_in(c_in), .op_sub(op_sub),
        .out_valid(ovld[2]), .out_ready(ordy[2]), .sum(s32),
        .c_out(cout[2]), .ovf(ovf[2]), .zero(zero[2]), .busy(busy[2])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int width_of(input int k);
        case (k)
            0:       return 16;
            1:       return 4;
            default: return 32;
        endcase
    endfunction

    // Reference from integer arithmetic: borrow test for subtract, signed range test for overflow.
    function automatic res_t gold(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic ci, input logic sub);
        longint mask, ua, ub, sa, sb, tot, sr, smax, smin;
        res_t   r;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        sa   = (ua > smax) ? ua - (longint'(1) << w) : ua;
        sb   = (ub > smax) ? ub - (longint'(1) << w) : ub;
        if (sub) begin
            tot = ua - ub;
            sr  = sa - sb;
            r.c = (ua >= ub);
        end else begin
            tot = ua + ub + longint'(ci);
            sr  = sa + sb + longint'(ci);
            r.c = ((tot >> w) & 1) != 0;
        end
        r.s = 32'(tot & mask);
        r.o = (sr > smax) || (sr < smin);
        r.z = ((tot & mask) == 0);
        return r;
    endfunction

    task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic sub, output res_t r, output int lat);
        int guard = 0;
        opa = a; opb = b; c_in = ci; op_sub = sub; iv[k] = 1'b1;
        while (!irdy[k] && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        iv[k] = 1'b0;
        lat = 0;
        while (!ovld[k] && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        r.s = sum_k[k]; r.c = cout[k]; r.o = ovf[k]; r.z = zero[k];
        ordy[k] = 1'b1;
        @(posedge clk); #1;
        ordy[k] = 1'b0;
    endtask

    task automatic rand_run(input int k, input int nops);
        res_t q[$];
        res_t e, g;
        int   sent = 0, got = 0, cyc = 0;
        int   w = width_of(k);
        int   budget = nops * (w / 4 + 2) * 4 + 200;
        bit   acc;
        while (got < nops && cyc < budget) begin
            if (!iv[k] && sent < nops && $urandom_range(0, 3) != 0) begin
                opa = $urandom; opb = $urandom;
                op_sub = 1'($urandom_range(0, 1)); c_in = 1'($urandom_range(0, 1));
                iv[k] = 1'b1;
            end
            ordy[k] = ($urandom_range(0, 2) != 0);
            acc = iv[k] && irdy[k];
            if (acc) begin
                q.push_back(gold(w, opa, opb, c_in, op_sub));
                sent++;
            end
            if (ovld[k] && ordy[k]) begin
                check($sformatf("rand_w%0d_expected", w), 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    g = '{s: sum_k[k], c: cout[k], o: ovf[k], z: zero[k]};
                    check($sformatf("rand_w%0d_result", w), 64'(g), 64'(e));
                end
                got++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) iv[k] = 1'b0;
        end
        iv[k]   = 1'b0;
        ordy[k] = 1'b0;
        check($sformatf("rand_w%0d_count", w), 64'(got), 64'(nops));
        check($sformatf("rand_w%0d_leftover", w), 64'(q.size()), 64'd0);
    endtask

    initial begin
        vec_t vecs[9];
        res_t r;
        int   lat;
        bit   seen;

        vecs[0] = '{16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready",  64'(irdy), 64'b111);
        check("reset_out_valid", 64'(ovld), 64'b000);
        check("reset_busy",      64'(busy), 64'b000);
        check("reset_flags",     64'({cout, ovf, zero}), 64'd0);
        check("reset_sum16",     64'(s16), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            do_op(0, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].ci, vecs[i].sub, r, lat);
            check($sformatf("vec%0d_sum", i),     64'(r.s), 64'(vecs[i].s));
            check($sformatf("vec%0d_c_out", i),   64'(r.c), 64'(vecs[i].c));
            check($sformatf("vec%0d_ovf", i),     64'(r.o), 64'(vecs[i].o));
            check($sformatf("vec%0d_zero", i),    64'(r.z), 64'(vecs[i].z));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
        end

        // Backpressure: result held in DONE while a new request is pending.
        opa = 32'h1111; opb = 32'h2222; c_in = 1'b0; op_sub = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        lat = 0;
        while (!ovld[0] && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        opa = 32'h0005; opb = 32'h0001; iv[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp%0d_out_valid", i), 64'(ovld[0]), 64'd1);
            check($sformatf("bp%0d_sum", i),       64'(s16), 64'h3333);
            check($sformatf("bp%0d_in_ready", i),  64'(irdy[0]), 64'd0);
            check($sformatf("bp%0d_flags", i),     64'({cout[0], ovf[0], zero[0]}), 64'd0);
            @(posedge clk); #1;
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        check("bp_release_in_ready",  64'(irdy[0]), 64'd1);
        check("bp_release_out_valid", 64'(ovld[0]), 64'd0);
        check("bp_release_busy",      64'(busy[0]), 64'd0);

        // Reset asserted during the second RUN cycle.
        opa = 32'h00FF; opb = 32'h0101; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        check("midrun_busy", 64'(busy[0]), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrun_rst_in_ready",  64'(irdy[0]), 64'd1);
        check("midrun_rst_out_valid", 64'(ovld[0]), 64'd0);
        check("midrun_rst_busy",      64'(busy[0]), 64'd0);
        check("midrun_rst_sum",       64'(s16), 64'd0);
        check("midrun_rst_flags",     64'({cout[0], ovf[0], zero[0]}), 64'd0);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            seen |= ovld[0];
        end
        check("midrun_no_result", 64'(seen), 64'd0);
        do_op(0, 32'h0001, 32'h0001, 1'b0, 1'b0, r, lat);
        check("after_rst_sum",     64'(r.s), 64'h0002);
        check("after_rst_latency", 64'(lat), 64'd4);

        // WIDTH=4: a single RUN cycle.
        do_op(1, 32'h9, 32'h8, 1'b0, 1'b0, r, lat);
        check("w4_sum",     64'(r.s), 64'h1);
        check("w4_c_out",   64'(r.c), 64'd1);
        check("w4_ovf",     64'(r.o), 64'd1);
        check("w4_latency", 64'(lat), 64'd1);

        rand_run(0, 60);
        rand_run(1, 60);
        rand_run(2, 60);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
